chacha_stream: RTL and testbench

- Stream-cipher front end that drives the ChaCha block core.
- Holds the key, nonce and 32-bit block counter, and serialises the 64-byte initial state into the core's byte-serial load port.
- Waits for the core's keystream, then XORs the 64 keystream bytes, in order, with a valid/ready byte stream.
- Re-keys the core automatically with counter+1 for each following block until stopped or the counter wraps.

---
 rtl/chacha_pkg.sv | 26 ++
 rtl/chacha_state_mux.sv | 18 +
 rtl/chacha_stream.sv | 135 +++++++++++++
 tb/tb_chacha_stream.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// chacha_pkg: shared constants and FSM encoding for the ChaCha stream front end
package chacha_pkg;

  // "expand 32-byte k" as four little-endian words
  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  // Word 0 sits in the low bits so byte i of this vector is state byte i
  localparam logic [127:0] SIGMA = {SIGMA3, SIGMA2, SIGMA1, SIGMA0};

  // Configuration address map
  localparam logic [5:0] KEY_BASE   = 6'd0;
  localparam logic [5:0] CTR_BASE   = 6'd32;
  localparam logic [5:0] NONCE_BASE = 6'd36;
  localparam logic [5:0] CFG_END    = 6'd48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_e;

endpackage

// File: rtl/chacha_state_mux.sv
// chacha_state_mux: selects one byte of the 64-byte ChaCha initial state
module chacha_state_mux
  import chacha_pkg::*;
(
  input  logic [5:0]   idx_i,
  input  logic [255:0] key_i,
  input  logic [95:0]  nonce_i,
  input  logic [31:0]  ctr_i,
  output logic [7:0]   byte_o
);

  logic [511:0] init_state;

  // Words laid out low to high so the byte index maps straight onto bit offset
  assign init_state = {nonce_i, ctr_i, key_i, SIGMA};
  assign byte_o     = init_state[{idx_i, 3'b000} +: 8];

endmodule

// File: rtl/chacha_stream.sv
// chacha_stream: holds key/nonce/counter, loads the ChaCha core byte-serially
// and XORs the returned keystream with a valid/ready byte stream
module chacha_stream
  import chacha_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        start,
  input  logic        stop,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        ctr_wrap,
  output logic [31:0] blk_ctr,
  output logic        core_write,
  output logic [7:0]  core_data_in,
  output logic [5:0]  core_addr,
  input  logic [7:0]  core_data_out,
  input  logic        core_ready
);

  state_e       state_q;
  logic [5:0]   idx_q;
  logic [255:0] key_q;
  logic [95:0]  nonce_q;
  logic [31:0]  ctr_q;
  logic         out_valid_q;
  logic [7:0]   out_data_q;
  logic         ctr_wrap_q;
  logic         wait_first_q;

  logic [7:0]   load_byte;
  logic         accept;
  logic [3:0]   nonce_off;

  chacha_state_mux u_state_mux (
    .idx_i   (idx_q),
    .key_i   (key_q),
    .nonce_i (nonce_q),
    .ctr_i   (ctr_q),
    .byte_o  (load_byte)
  );

  assign nonce_off    = 4'(cfg_addr - NONCE_BASE);
  assign in_ready     = (state_q == STREAM) && (!out_valid_q || out_ready);
  assign accept       = in_valid && in_ready;
  assign core_write   = (state_q == LOAD);
  assign core_data_in = core_write ? load_byte : 8'h00;
  assign core_addr    = (state_q == LOAD || state_q == STREAM) ? idx_q : 6'd0;
  assign busy         = (state_q != IDLE);
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign ctr_wrap     = ctr_wrap_q;
  assign blk_ctr      = ctr_q;

  // Control FSM, configuration registers and the one-entry output buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 6'd0;
      key_q        <= '0;
      nonce_q      <= '0;
      ctr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      ctr_wrap_q   <= 1'b0;
      wait_first_q <= 1'b0;
    end else if (stop) begin
      state_q     <= IDLE;
      idx_q       <= 6'd0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (cfg_we) begin
            if (cfg_addr < CTR_BASE) begin
              key_q[{cfg_addr[4:0], 3'b000} +: 8] <= cfg_data;
            end else if (cfg_addr < NONCE_BASE) begin
              ctr_q[{cfg_addr[1:0], 3'b000} +: 8] <= cfg_data;
            end else if (cfg_addr < CFG_END) begin
              nonce_q[{nonce_off, 3'b000} +: 8] <= cfg_data;
            end
          end
          if (start) begin
            state_q    <= LOAD;
            idx_q      <= 6'd0;
            ctr_wrap_q <= 1'b0;
          end
        end
        LOAD: begin
          idx_q <= idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_q      <= WAIT;
            wait_first_q <= 1'b1;
          end
        end
        WAIT: begin
          wait_first_q <= 1'b0;
          if (!wait_first_q && core_ready) begin
            state_q <= STREAM;
            idx_q   <= 6'd0;
          end
        end
        STREAM: begin
          if (accept) begin
            out_data_q  <= in_data ^ core_data_out;
            out_valid_q <= 1'b1;
            idx_q       <= idx_q + 6'd1;
            if (idx_q == 6'd63) begin
              if (ctr_q == 32'hFFFF_FFFF) begin
                ctr_wrap_q <= 1'b1;
                state_q    <= IDLE;
              end else begin
                ctr_q   <= ctr_q + 32'd1;
                state_q <= LOAD;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream.sv
// tb_chacha_stream: randomized checks of chacha_stream against a ChaCha20 reference
module tb_chacha_stream;

  logic        clk = 1'b0;
  logic        rst_n, cfg_we, start, stop, in_valid, out_ready, core_ready;
  logic [5:0]  cfg_addr, core_addr;
  logic [7:0]  cfg_data, in_data, out_data, core_data_in, core_data_out;
  logic        in_ready, out_valid, busy, ctr_wrap, core_write;
  logic [31:0] blk_ctr;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  tbKey[32];
  logic [7:0]  tbNonce[12];
  logic [31:0] tbCtr;
  logic [7:0]  ptIn[$];
  logic [7:0]  ctOut[$];
  logic [7:0]  expQ[$];

  localparam int CORE_LAT = 162;
  logic [511:0] coreMem = '0;
  logic [511:0] coreKs  = '0;
  logic         coreReady = 1'b0;
  int           coreCnt = -1;
  int           runCnt = 0;
  int           lastRun = 0;

  always #5 clk = ~clk;

  chacha_stream dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .ctr_wrap(ctr_wrap), .blk_ctr(blk_ctr), .core_write(core_write), .core_data_in(core_data_in),
    .core_addr(core_addr), .core_data_out(core_data_out), .core_ready(core_ready)
  );

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // ChaCha20 block function on a little-endian packed 16-word state
  function automatic logic [511:0] chachaBlock(input logic [511:0] st);
    logic [31:0]  x[16];
    logic [511:0] res;
    int a, b, c, d;
    for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (k < 4) begin a = k; b = 4 + k; c = 8 + k; d = 12 + k; end
        else begin a = k - 4; b = 4 + (k - 3) % 4; c = 8 + (k - 2) % 4; d = 12 + (k - 1) % 4; end
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + st[32*i +: 32];
    return res;
  endfunction

  // Initial state built word by word from the bench's key, nonce and counter
  function automatic logic [511:0] refState(input logic [31:0] ctr);
    logic [31:0]  w[16];
    logic [511:0] st;
    w[0] = 32'h61707865; w[1] = 32'h3320646e; w[2] = 32'h79622d32; w[3] = 32'h6b206574;
    for (int k = 0; k < 8; k++)
      w[4+k] = {tbKey[4*k+3], tbKey[4*k+2], tbKey[4*k+1], tbKey[4*k]};
    w[12] = ctr;
    for (int k = 0; k < 3; k++)
      w[13+k] = {tbNonce[4*k+3], tbNonce[4*k+2], tbNonce[4*k+1], tbNonce[4*k]};
    for (int i = 0; i < 16; i++) st[32*i +: 32] = w[i];
    return st;
  endfunction

  function automatic void buildExpected(input int n, input logic [31:0] ctr0);
    logic [511:0] ks;
    ks = '0;
    expQ.delete();
    for (int i = 0; i < n; i++) begin
      if (i % 64 == 0) ks = chachaBlock(refState(ctr0 + 32'(i / 64)));
      expQ.push_back(ptIn[i] ^ ks[8*(i%64) +: 8]);
    end
  endfunction

  // Behavioural ChaCha core: byte-serial load, fixed latency, then keystream
  assign core_data_out = coreKs[{core_addr, 3'b000} +: 8];
  assign core_ready    = coreReady;

  always @(posedge clk) begin
    if (!rst_n) begin
      coreReady <= 1'b0;
      coreCnt   <= -1;
    end else if (core_write) begin
      coreMem[{core_addr, 3'b000} +: 8] <= core_data_in;
      coreReady <= 1'b0;
      coreCnt   <= (core_addr == 6'd63) ? CORE_LAT : -1;
    end else if (coreCnt > 0) begin
      coreCnt <= coreCnt - 1;
    end else if (coreCnt == 0) begin
      coreKs    <= chachaBlock(coreMem);
      coreReady <= 1'b1;
      coreCnt   <= -1;
    end
  end

  // Length of the most recent uninterrupted core_write burst
  always @(posedge clk) begin
    if (core_write) runCnt <= runCnt + 1;
    else begin
      if (runCnt != 0) lastRun <= runCnt;
      runCnt <= 0;
    end
  end

  task automatic cfgWrite(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
  endtask

  task automatic programAll();
    for (int i = 0; i < 32; i++) cfgWrite(6'(i), tbKey[i]);
    for (int j = 0; j < 4; j++) cfgWrite(6'(32 + j), tbCtr[8*j +: 8]);
    for (int k = 0; k < 12; k++) cfgWrite(6'(36 + k), tbNonce[k]);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic randomConfig();
    for (int i = 0; i < 32; i++) tbKey[i] = 8'($urandom_range(255));
    for (int k = 0; k < 12; k++) tbNonce[k] = 8'($urandom_range(255));
    tbCtr = $urandom & 32'h7FFF_FFFF;
  endtask

  task automatic randomPlain(input int n);
    ptIn.delete();
    for (int i = 0; i < n; i++) ptIn.push_back(8'($urandom_range(255)));
  endtask

  task automatic pulseStart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulseStop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  // Push ptIn through the DUT and collect ciphertext, watching handshake rules
  task automatic streamBytes(input int n, input int readyPct, input int validPct,
                             input int cfgCycle, output int violations, output bit timedOut);
    int sent, cyc, budget;
    bit prevHold;
    logic [7:0] prevData;
    sent = 0; cyc = 0; prevHold = 1'b0; prevData = 8'h00;
    budget = n * 10 + 500 * (n / 64 + 2);
    violations = 0; timedOut = 1'b0;
    ctOut.delete();
    while (ctOut.size() < n) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < readyPct);
      in_valid  = (sent < n) && ($urandom_range(99) < validPct);
      in_data   = (sent < n) ? ptIn[sent] : 8'h00;
      if (cyc == cfgCycle) begin
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = ~tbKey[0];
      end else if (cyc == cfgCycle + 1) begin
        cfg_we = 1'b1; cfg_addr = 6'd32; cfg_data = ~tbCtr[7:0];
      end else begin
        cfg_we = 1'b0;
      end
      #1;
      if (prevHold && (out_valid !== 1'b1 || out_data !== prevData)) violations++;
      if (out_valid && !out_ready && in_ready) violations++;
      if (core_write && in_ready) violations++;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) ctOut.push_back(out_data);
      prevHold = out_valid && !out_ready;
      prevData = out_data;
      cyc++;
      if (cyc > budget) begin timedOut = 1'b1; break; end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [58:0] obs;
    obs = {busy, out_valid, ctr_wrap, core_write, in_ready, out_data, core_addr, core_data_in, blk_ctr};
    compared++;
    if (obs !== 59'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
  endtask

  task automatic test_block_vector();
    int viol; bit to;
    for (int i = 0; i < 32; i++) tbKey[i] = 8'(i);
    tbNonce = '{8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h4a, 8'h00, 8'h00, 8'h00, 8'h00};
    tbCtr = 32'd1;
    ptIn.delete();
    for (int i = 0; i < 64; i++) ptIn.push_back(8'h00);
    programAll();
    pulseStart();
    streamBytes(64, 100, 100, -10, viol, to);
    buildExpected(64, 32'd1);
    compared++;
    if (to || ctOut.size() != 64) begin
      mismatched++; $display("[TB] FAIL blk_count: got %0d bytes expected 64", ctOut.size());
    end
    if (ctOut.size() >= 4) begin
      compared++;
      if ({ctOut[0], ctOut[1], ctOut[2], ctOut[3]} !== 32'h10f1e7e4) begin
        mismatched++;
        $display("[TB] FAIL blk_rfc_head: got %h%h%h%h expected 10f1e7e4", ctOut[0], ctOut[1], ctOut[2], ctOut[3]);
      end
    end
    for (int i = 0; i < ctOut.size() && i < 64; i++) begin
      compared++;
      if (ctOut[i] !== expQ[i]) begin
        mismatched++; $display("[TB] FAIL blk_byte[%0d]: got %h expected %h", i, ctOut[i], expQ[i]);
      end
    end
    compared++;
    if (blk_ctr !== 32'd2) begin
      mismatched++; $display("[TB] FAIL blk_ctr_next: got %h expected 2", blk_ctr);
    end
    pulseStop();
  endtask

  task automatic test_encrypt();
    int viol; bit to;
    string s;
    s = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    for (int i = 0; i < 32; i++) tbKey[i] = 8'(i);
    tbNonce = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h4a, 8'h00, 8'h00, 8'h00, 8'h00};
    tbCtr = 32'd1;
    ptIn.delete();
    for (int i = 0; i < s.len(); i++) ptIn.push_back(s[i]);
    programAll();
    pulseStart();
    streamBytes(s.len(), 100, 100, -10, viol, to);
    buildExpected(s.len(), 32'd1);
    compared++;
    if (to || ctOut.size() != s.len()) begin
      mismatched++; $display("[TB] FAIL enc_count: got %0d bytes expected %0d", ctOut.size(), s.len());
    end
    if (ctOut.size() >= 4) begin
      compared++;
      if ({ctOut[0], ctOut[1], ctOut[2], ctOut[3]} !== 32'h6e2e359a) begin
        mismatched++;
        $display("[TB] FAIL enc_rfc_head: got %h%h%h%h expected 6e2e359a", ctOut[0], ctOut[1], ctOut[2], ctOut[3]);
      end
    end
    for (int i = 0; i < ctOut.size() && i < s.len(); i++) begin
      compared++;
      if (ctOut[i] !== expQ[i]) begin
        mismatched++; $display("[TB] FAIL enc_byte[%0d]: got %h expected %h", i, ctOut[i], expQ[i]);
      end
    end
    compared++;
    if (lastRun !== 64 || blk_ctr !== 32'd2) begin
      mismatched++; $display("[TB] FAIL enc_reload: got run %0d ctr %h expected run 64 ctr 2", lastRun, blk_ctr);
    end
    pulseStop();
  endtask

  task automatic test_backpressure();
    int viol; bit to;
    randomConfig();
    randomPlain(150);
    programAll();
    pulseStart();
    streamBytes(150, 50, 70, -10, viol, to);
    buildExpected(150, tbCtr);
    compared++;
    if (to || ctOut.size() != 150) begin
      mismatched++; $display("[TB] FAIL bp_count: got %0d bytes expected 150", ctOut.size());
    end
    for (int i = 0; i < ctOut.size() && i < 150; i++) begin
      compared++;
      if (ctOut[i] !== expQ[i]) begin
        mismatched++; $display("[TB] FAIL bp_byte[%0d]: got %h expected %h", i, ctOut[i], expQ[i]);
      end
    end
    compared++;
    if (viol != 0) begin
      mismatched++; $display("[TB] FAIL bp_handshake: got %0d violations expected 0", viol);
    end
    pulseStop();
  endtask

  task automatic test_ctr_wrap();
    int viol; bit to;
    randomConfig();
    tbCtr = 32'hFFFF_FFFF;
    randomPlain(64);
    programAll();
    pulseStart();
    streamBytes(64, 100, 100, -10, viol, to);
    buildExpected(64, 32'hFFFF_FFFF);
    compared++;
    if (to || ctOut.size() != 64) begin
      mismatched++; $display("[TB] FAIL wrap_count: got %0d bytes expected 64", ctOut.size());
    end
    for (int i = 0; i < ctOut.size() && i < 64; i++) begin
      compared++;
      if (ctOut[i] !== expQ[i]) begin
        mismatched++; $display("[TB] FAIL wrap_byte[%0d]: got %h expected %h", i, ctOut[i], expQ[i]);
      end
    end
    compared++;
    if ({ctr_wrap, busy, in_ready, blk_ctr} !== {3'b100, 32'hFFFF_FFFF}) begin
      mismatched++;
      $display("[TB] FAIL wrap_status: got wrap=%b busy=%b in_ready=%b ctr=%h expected 1 0 0 ffffffff",
               ctr_wrap, busy, in_ready, blk_ctr);
    end
    pulseStart();
    compared++;
    if (ctr_wrap !== 1'b0 || busy !== 1'b1) begin
      mismatched++; $display("[TB] FAIL wrap_clear: got wrap=%b busy=%b expected 0 1", ctr_wrap, busy);
    end
    pulseStop();
  endtask

  task automatic test_abort();
    int viol, n; bit to, found;
    randomConfig();
    randomPlain(64);
    programAll();
    pulseStart();
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (core_write && core_addr == 6'd30) begin found = 1'b1; break; end
      @(negedge clk);
    end
    compared++;
    if (!found) begin
      mismatched++; $display("[TB] FAIL abort_reach_idx30: got none expected core_addr 30 within 200 cycles");
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    compared++;
    if (core_write !== 1'b0 || busy !== 1'b0 || blk_ctr !== tbCtr) begin
      mismatched++;
      $display("[TB] FAIL abort_idle: got write=%b busy=%b ctr=%h expected 0 0 %h", core_write, busy, blk_ctr, tbCtr);
    end
    @(negedge clk);
    compared++;
    if (lastRun !== 31) begin
      mismatched++; $display("[TB] FAIL abort_partial_run: got %0d expected 31", lastRun);
    end
    pulseStart();
    n = 64;
    streamBytes(n, 100, 100, -10, viol, to);
    buildExpected(n, tbCtr);
    compared++;
    if (to || ctOut.size() != n || lastRun !== 64) begin
      mismatched++; $display("[TB] FAIL abort_reload: got %0d bytes run %0d expected 64 bytes run 64", ctOut.size(), lastRun);
    end
    for (int i = 0; i < ctOut.size() && i < n; i++) begin
      compared++;
      if (ctOut[i] !== expQ[i]) begin
        mismatched++; $display("[TB] FAIL abort_byte[%0d]: got %h expected %h", i, ctOut[i], expQ[i]);
      end
    end
    pulseStop();
  endtask

  task automatic test_cfg_guard_and_reset();
    int viol; bit to, found;
    randomConfig();
    randomPlain(128);
    programAll();
    pulseStart();
    streamBytes(128, 100, 100, 250, viol, to);
    buildExpected(128, tbCtr);
    compared++;
    if (to || ctOut.size() != 128) begin
      mismatched++; $display("[TB] FAIL guard_count: got %0d bytes expected 128", ctOut.size());
    end
    for (int i = 0; i < ctOut.size() && i < 128; i++) begin
      compared++;
      if (ctOut[i] !== expQ[i]) begin
        mismatched++; $display("[TB] FAIL guard_byte[%0d]: got %h expected %h", i, ctOut[i], expQ[i]);
      end
    end
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy && !core_write) begin found = 1'b1; break; end
    end
    compared++;
    if (!found) begin
      mismatched++; $display("[TB] FAIL rst_reach_wait: got none expected WAIT within 200 cycles");
    end
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) tbKey[i] = 8'h00;
    for (int k = 0; k < 12; k++) tbNonce[k] = 8'h00;
    tbCtr = 32'd0;
    randomPlain(64);
    pulseStart();
    streamBytes(64, 100, 100, -10, viol, to);
    buildExpected(64, 32'd0);
    compared++;
    if (to || ctOut.size() != 64) begin
      mismatched++; $display("[TB] FAIL rst_count: got %0d bytes expected 64", ctOut.size());
    end
    for (int i = 0; i < ctOut.size() && i < 64; i++) begin
      compared++;
      if (ctOut[i] !== expQ[i]) begin
        mismatched++; $display("[TB] FAIL rst_byte[%0d]: got %h expected %h", i, ctOut[i], expQ[i]);
      end
    end
    pulseStop();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_data = 8'h00;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_block_vector();
    test_encrypt();
    test_backpressure();
    test_ctr_wrap();
    test_abort();
    test_cfg_guard_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
